// File: rtl/out_flush_sequencer_pkg.sv
// Shared definitions for the output flush sequencer: array geometry defaults
// and the flush FSM state encoding shared with the array controller.
package out_flush_sequencer_pkg;

    localparam int DEF_PE_ARRAY_NUM_ROWS      = 32;
    localparam int DEF_PE_ARRAY_NUM_ROWS_LOG2 = 5;
    localparam int DEF_OUT_SRAM_AWIDTH        = 10;
    localparam int DEF_TILE_ID_WIDTH          = 5;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_SHIFT = 2'd1,
        FLUSH_DRAIN = 2'd2
    } flush_state_e;

endpackage

// File: rtl/out_tile_addr_calc.sv
// Tile-major base address: ((row * cols_per_row + col) << row_shift), truncated
// to the SRAM address width. Purely combinational.
module out_tile_addr_calc
    import out_flush_sequencer_pkg::*;
#(
    parameter int ID_W  = DEF_TILE_ID_WIDTH,
    parameter int SHIFT = DEF_PE_ARRAY_NUM_ROWS_LOG2,
    parameter int AW    = DEF_OUT_SRAM_AWIDTH
) (
    input  logic [ID_W-1:0] tile_row_id,
    input  logic [ID_W-1:0] tile_col_id,
    input  logic [ID_W-1:0] num_tile_col_ids,
    output logic [AW-1:0]   base_addr
);

    // Wide enough for max_row * max_cols + max_col without wrap.
    localparam int LIN_W = 2 * ID_W + 1;

    logic [LIN_W-1:0] tile_lin;

    always_comb begin
        tile_lin  = LIN_W'(tile_row_id) * LIN_W'(num_tile_col_ids) + LIN_W'(tile_col_id);
        base_addr = AW'(tile_lin) << SHIFT;
    end

endmodule

// File: rtl/out_flush_sequencer.sv
// Drains the PE array one row per cycle after a tile completes and writes the
// active rows to the output SRAM at tile-major addresses.
module out_flush_sequencer
    import out_flush_sequencer_pkg::*;
#(
    parameter int PE_ARRAY_NUM_ROWS      = DEF_PE_ARRAY_NUM_ROWS,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = DEF_PE_ARRAY_NUM_ROWS_LOG2,
    parameter int OUT_SRAM_AWIDTH        = DEF_OUT_SRAM_AWIDTH,
    parameter int TILE_ID_WIDTH          = DEF_TILE_ID_WIDTH
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              STALL,
    input  logic                              FLUSH_START_in,
    input  logic [TILE_ID_WIDTH-1:0]          TILE_ROW_ID_in,
    input  logic [TILE_ID_WIDTH-1:0]          TILE_COL_ID_in,
    input  logic [TILE_ID_WIDTH-1:0]          NUM_TILE_COL_IDS_in,
    input  logic [PE_ARRAY_NUM_ROWS_LOG2:0]   NUM_ACTV_ROWS_in,
    output logic                              PE_ROW_SHIFT_out,
    output logic                              OUT_SRAM_WE_out,
    output logic [OUT_SRAM_AWIDTH-1:0]        OUT_SRAM_ADDR_out,
    output logic                              FLUSH_BUSY_out,
    output logic                              FLUSH_DONE_out,
    output flush_state_e                      FLUSH_STATE_dbg
);

    localparam int ACTV_W = PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam logic [ACTV_W-1:0] MAX_ACTV = ACTV_W'(PE_ARRAY_NUM_ROWS);
    localparam logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] LAST_ROW =
        PE_ARRAY_NUM_ROWS_LOG2'(PE_ARRAY_NUM_ROWS - 1);

    flush_state_e                      state;
    logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] row_cnt;
    logic [ACTV_W-1:0]                 actv_rows_q;
    logic [OUT_SRAM_AWIDTH-1:0]        base_addr_q;
    logic                              p_vld;
    logic [OUT_SRAM_AWIDTH-1:0]        p_addr;

    logic [OUT_SRAM_AWIDTH-1:0]        calc_base;
    logic [ACTV_W-1:0]                 actv_clamped;
    logic [OUT_SRAM_AWIDTH-1:0]        row_addr;
    logic                              row_active;
    logic                              last_row;
    logic                              accept;

    out_tile_addr_calc #(
        .ID_W  (TILE_ID_WIDTH),
        .SHIFT (PE_ARRAY_NUM_ROWS_LOG2),
        .AW    (OUT_SRAM_AWIDTH)
    ) u_addr_calc (
        .tile_row_id      (TILE_ROW_ID_in),
        .tile_col_id      (TILE_COL_ID_in),
        .num_tile_col_ids (NUM_TILE_COL_IDS_in),
        .base_addr        (calc_base)
    );

    // Request handshake: FLUSH_START_in is a single-cycle request with no ready
    // return. It is taken when STALL is low and the sequencer is in IDLE or in
    // its final DRAIN cycle (so flushes can chain back to back); otherwise dropped.
    always_comb begin
        actv_clamped = (NUM_ACTV_ROWS_in > MAX_ACTV) ? MAX_ACTV : NUM_ACTV_ROWS_in;
        row_addr     = base_addr_q + OUT_SRAM_AWIDTH'(row_cnt);
        row_active   = ACTV_W'(row_cnt) < actv_rows_q;
        last_row     = (row_cnt == LAST_ROW);
        accept       = FLUSH_START_in && !STALL &&
                       ((state == FLUSH_IDLE) || (state == FLUSH_DRAIN));
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= FLUSH_IDLE;
            row_cnt     <= '0;
            actv_rows_q <= '0;
            base_addr_q <= '0;
            p_vld       <= 1'b0;
            p_addr      <= '0;
        end else if (!STALL) begin
            case (state)
                FLUSH_IDLE: begin
                    p_vld <= 1'b0;
                end
                FLUSH_SHIFT: begin
                    // Rows past the active count are shifted out to clear the
                    // array but never reach the SRAM.
                    p_vld   <= row_active;
                    p_addr  <= row_addr;
                    row_cnt <= row_cnt + 1'b1;
                    if (last_row) begin
                        state <= FLUSH_DRAIN;
                    end
                end
                FLUSH_DRAIN: begin
                    p_vld <= 1'b0;
                    state <= FLUSH_IDLE;
                end
                default: begin
                    p_vld <= 1'b0;
                    state <= FLUSH_IDLE;
                end
            endcase

            if (accept) begin
                actv_rows_q <= actv_clamped;
                base_addr_q <= calc_base;
                row_cnt     <= '0;
                state       <= FLUSH_SHIFT;
            end
        end
    end

    assign PE_ROW_SHIFT_out  = (state == FLUSH_SHIFT) && !STALL;
    assign OUT_SRAM_WE_out   = p_vld && !STALL;
    assign OUT_SRAM_ADDR_out = p_addr;
    assign FLUSH_BUSY_out    = (state != FLUSH_IDLE);
    assign FLUSH_DONE_out    = (state == FLUSH_DRAIN) && !STALL;
    assign FLUSH_STATE_dbg   = state;

endmodule

// File: tb/tb_out_flush_sequencer.sv
// Directed and randomized checks of out_flush_sequencer against a timeline model
// of a flush: unstalled cycle k after acceptance shifts (1..32), writes row k-2, done at 33.
module tb_out_flush_sequencer;
    import out_flush_sequencer_pkg::*;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         STALL;
    logic         FLUSH_START_in;
    logic [4:0]   TILE_ROW_ID_in;
    logic [4:0]   TILE_COL_ID_in;
    logic [4:0]   NUM_TILE_COL_IDS_in;
    logic [5:0]   NUM_ACTV_ROWS_in;
    logic         PE_ROW_SHIFT_out;
    logic         OUT_SRAM_WE_out;
    logic [9:0]   OUT_SRAM_ADDR_out;
    logic         FLUSH_BUSY_out;
    logic         FLUSH_DONE_out;
    flush_state_e FLUSH_STATE_dbg;

    out_flush_sequencer dut (
        .CLK                 (CLK),
        .RSTn                (RSTn),
        .STALL               (STALL),
        .FLUSH_START_in      (FLUSH_START_in),
        .TILE_ROW_ID_in      (TILE_ROW_ID_in),
        .TILE_COL_ID_in      (TILE_COL_ID_in),
        .NUM_TILE_COL_IDS_in (NUM_TILE_COL_IDS_in),
        .NUM_ACTV_ROWS_in    (NUM_ACTV_ROWS_in),
        .PE_ROW_SHIFT_out    (PE_ROW_SHIFT_out),
        .OUT_SRAM_WE_out     (OUT_SRAM_WE_out),
        .OUT_SRAM_ADDR_out   (OUT_SRAM_ADDR_out),
        .FLUSH_BUSY_out      (FLUSH_BUSY_out),
        .FLUSH_DONE_out      (FLUSH_DONE_out),
        .FLUSH_STATE_dbg     (FLUSH_STATE_dbg)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the flush timeline, counted in unstalled cycles.
    bit         m_on;
    int         m_pos;
    int         m_actv;
    int         m_base;
    logic [9:0] exp_q[$];

    int cyc;
    int done_cyc;
    int wr_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_shift"}, PE_ROW_SHIFT_out, 0);
        check({tag, "_we"},    OUT_SRAM_WE_out, 0);
        check({tag, "_addr"},  OUT_SRAM_ADDR_out, 0);
        check({tag, "_busy"},  FLUSH_BUSY_out, 0);
        check({tag, "_done"},  FLUSH_DONE_out, 0);
    endtask

    // Driver: one clock cycle with the given inputs; checks at the falling edge.
    task automatic do_cycle(input bit stall, input bit start,
                            input int row, input int col, input int ncol, input int actv);
        bit         e_shift, e_we, e_done, e_busy, acc;
        logic [9:0] e_addr;
        STALL               = stall;
        FLUSH_START_in      = start;
        TILE_ROW_ID_in      = 5'(row);
        TILE_COL_ID_in      = 5'(col);
        NUM_TILE_COL_IDS_in = 5'(ncol);
        NUM_ACTV_ROWS_in    = 6'(actv);
        @(negedge CLK);
        e_busy  = m_on;
        e_shift = m_on && !stall && (m_pos <= 32);
        e_we    = m_on && !stall && (m_pos >= 2) && ((m_pos - 2) < m_actv);
        e_done  = m_on && !stall && (m_pos == 33);
        check("shift", PE_ROW_SHIFT_out, e_shift);
        check("we",    OUT_SRAM_WE_out, e_we);
        check("busy",  FLUSH_BUSY_out, e_busy);
        check("done",  FLUSH_DONE_out, e_done);
        if (e_we) begin
            e_addr = exp_q.pop_front();
            check("addr", OUT_SRAM_ADDR_out, e_addr);
        end
        if (OUT_SRAM_WE_out) wr_cnt++;
        if (FLUSH_DONE_out) done_cyc = cyc;
        acc = start && !stall && (!m_on || (m_pos == 33));
        if (!stall && m_on) begin
            if (m_pos == 33) m_on = 1'b0;
            else m_pos++;
        end
        if (acc) begin
            m_on   = 1'b1;
            m_pos  = 1;
            m_actv = (actv > 32) ? 32 : actv;
            m_base = ((row * ncol + col) * 32) % 1024;
            for (int r = 0; r < m_actv; r++) exp_q.push_back(10'((m_base + r) % 1024));
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // One flush started in cycle 0, optional stall window, junk config afterwards.
    task automatic run_flush(input int row, input int col, input int ncol, input int actv,
                             input int stall_lo, input int stall_hi, input int ncyc);
        cyc      = 0;
        wr_cnt   = 0;
        done_cyc = -1;
        do_cycle(1'b0, 1'b1, row, col, ncol, actv);
        for (int c = 1; c <= ncyc; c++) begin
            do_cycle((c >= stall_lo) && (c <= stall_hi), 1'b0,
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 63));
        end
    endtask

    initial begin
        RSTn = 1'b0;
        STALL = 1'b0;
        FLUSH_START_in = 1'b0;
        TILE_ROW_ID_in = '0;
        TILE_COL_ID_in = '0;
        NUM_TILE_COL_IDS_in = '0;
        NUM_ACTV_ROWS_in = '0;
        m_on = 1'b0;
        m_pos = 0;
        cyc = 0;
        #12;
        check_all_zero("reset");
        check("reset_state", FLUSH_STATE_dbg, FLUSH_IDLE);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Tile (1,2) of 3 columns, full tile: base 160
        run_flush(1, 2, 3, 32, -1, -1, 36);
        check("t1_done_cycle", done_cyc, 33);
        check("t1_writes", wr_cnt, 32);

        // Five active rows at tile (0,0)
        run_flush(0, 0, 4, 5, -1, -1, 36);
        check("t2_done_cycle", done_cyc, 33);
        check("t2_writes", wr_cnt, 5);

        // Stall cycles 10..12 push DONE out by three cycles
        run_flush(2, 1, 4, 32, 10, 12, 40);
        check("t3_done_cycle", done_cyc, 36);
        check("t3_writes", wr_cnt, 32);

        // Tile (15,15) of 16 columns wraps to base 992
        run_flush(15, 15, 16, 32, -1, -1, 36);
        check("t4_writes", wr_cnt, 32);

        // Zero active rows: full shift, no writes, DONE still pulses
        run_flush(3, 3, 5, 0, -1, -1, 36);
        check("t5_done_cycle", done_cyc, 33);
        check("t5_writes", wr_cnt, 0);

        // Oversized row count clamps to the array height
        run_flush(0, 7, 8, 45, -1, -1, 36);
        check("t6_writes", wr_cnt, 32);

        // Request mid-flush is dropped; request in the DRAIN cycle chains
        cyc = 0; wr_cnt = 0; done_cyc = -1;
        do_cycle(1'b0, 1'b1, 3, 1, 5, 20);
        for (int c = 1; c <= 32; c++) do_cycle(1'b0, (c == 5), 9, 9, 9, 32);
        do_cycle(1'b0, 1'b1, 0, 1, 2, 7);
        for (int c = 34; c <= 70; c++) do_cycle(1'b0, 1'b0, 0, 0, 0, 0);
        check("t7_done_cycle", done_cyc, 66);
        check("t7_writes", wr_cnt, 27);

        // Asynchronous reset in cycle 15 of a flush
        cyc = 0;
        do_cycle(1'b0, 1'b1, 4, 2, 6, 32);
        for (int c = 1; c <= 14; c++) do_cycle(1'b0, 1'b0, 0, 0, 0, 0);
        #2;
        RSTn = 1'b0;
        #1;
        check_all_zero("midrst");
        m_on = 1'b0;
        exp_q.delete();
        @(posedge CLK);
        #1;
        check_all_zero("midrst_hold");
        RSTn = 1'b1;
        run_flush(1, 1, 2, 3, -1, -1, 36);
        check("t8_done_cycle", done_cyc, 33);
        check("t8_writes", wr_cnt, 3);

        // Random traffic: requests, stalls and config changes at any time
        for (int i = 0; i < 500; i++) begin
            do_cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 40));
        end
        for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'b0, 0, 0, 0, 0);
        check("rand_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
